// File: rtl/secuenciador_mac.sv
`default_nettype none
// ============================================================================
//  Module      : secuenciador_mac
//  Description : Dot-product sequencer/accumulator. Steps the operand-mux
//                select through the terms, multiplies the selected operands,
//                accumulates them and offers the sum over a valid/ready
//                handshake. Optional macro MAC_PIPE_EN registers the product
//                before accumulation and adds a DRAIN state.
//  Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_mac #(
   parameter int WIDTH     = 8,
   parameter int NTERMS    = 4,
   parameter int ACC_WIDTH = 2*WIDTH+3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     ina,
   input  logic [WIDTH-1:0]     inb,
   output logic [2:0]           sel,
   output logic                 busy,
   output logic                 valid,
   input  logic                 ready,
   output logic [ACC_WIDTH-1:0] result
);

   localparam logic [2:0] c_idx_last = 3'(NTERMS-1);
   localparam int         c_pad      = ACC_WIDTH - 2*WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_OUT   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [2:0]             r_idx;
   logic [ACC_WIDTH-1:0]   r_acc;
   logic [ACC_WIDTH-1:0]   r_result;
   logic                   r_valid;
   logic [2*WIDTH-1:0]     w_prod;
   logic [ACC_WIDTH-1:0]   w_prod_ext;
   logic                   w_last;
   logic                   w_accept;
   logic                   w_start_acc;

   assign w_prod      = ina * inb;
   assign w_prod_ext  = {{c_pad{1'b0}}, w_prod};
   assign w_last      = (r_idx == c_idx_last);
   // Valid is always set in OUT, so an accept is simply OUT with ready high
   assign w_accept    = (r_state == S_OUT) && ready;
   assign w_start_acc = ((r_state == S_IDLE) && start) || (w_accept && start);

`ifdef MAC_PIPE_EN
   logic [2*WIDTH-1:0]     r_prod_q;
   logic [ACC_WIDTH-1:0]   w_prodq_ext;
   assign w_prodq_ext = {{c_pad{1'b0}}, r_prod_q};
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_ISSUE;
`ifdef MAC_PIPE_EN
         S_ISSUE: if (w_last) w_state_nxt = S_DRAIN;
         S_DRAIN: w_state_nxt = S_OUT;
`else
         S_ISSUE: if (w_last) w_state_nxt = S_OUT;
         S_DRAIN: w_state_nxt = S_IDLE;   // unreachable without the pipeline
`endif
         S_OUT:   if (ready) w_state_nxt = start ? S_ISSUE : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Term index, accumulator, result and valid flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= 3'd0;
         r_acc    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
`ifdef MAC_PIPE_EN
         r_prod_q <= '0;
`endif
      end else begin
         if (w_start_acc) begin
            r_idx    <= 3'd0;
            r_acc    <= '0;
`ifdef MAC_PIPE_EN
            r_prod_q <= '0;
`endif
         end else if (r_state == S_ISSUE) begin
`ifdef MAC_PIPE_EN
            // Product of this term lands next cycle; add the previous one now
            r_prod_q <= w_prod;
            r_acc    <= r_acc + w_prodq_ext;
            if (!w_last) r_idx <= r_idx + 3'd1;
`else
            r_acc <= r_acc + w_prod_ext;
            if (!w_last) begin
               r_idx <= r_idx + 3'd1;
            end else begin
               r_result <= r_acc + w_prod_ext;
               r_valid  <= 1'b1;
            end
`endif
         end
`ifdef MAC_PIPE_EN
         else if (r_state == S_DRAIN) begin
            r_result <= r_acc + w_prodq_ext;
            r_valid  <= 1'b1;
         end
`endif
         if (w_accept) r_valid <= 1'b0;
      end
   end

   assign sel    = (r_state == S_ISSUE) ? r_idx : 3'd0;
   assign busy   = (r_state != S_IDLE);
   assign valid  = r_valid;
   assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_secuenciador_mac
//  Description : Directed bench for secuenciador_mac with 4-, 8- and 1-term
//                instances fed by behavioural operand muxes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_secuenciador_mac;

`ifdef MAC_PIPE_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // operand tables, indexed by each instance's sel
   logic [7:0] a4 [8];
   logic [7:0] b4 [8];
   logic [7:0] a8 [8];
   logic [7:0] b8 [8];
   logic [7:0] a1 [8];
   logic [7:0] b1 [8];

   logic        start4, ready4, busy4, valid4;
   logic        start8, ready8, busy8, valid8;
   logic        start1, ready1, busy1, valid1;
   logic [2:0]  sel4, sel8, sel1;
   logic [7:0]  ina4, inb4, ina8, inb8, ina1, inb1;
   logic [18:0] res4, res8, res1;

   assign ina4 = a4[sel4];
   assign inb4 = b4[sel4];
   assign ina8 = a8[sel8];
   assign inb8 = b8[sel8];
   assign ina1 = a1[sel1];
   assign inb1 = b1[sel1];

   secuenciador_mac #(.WIDTH(8), .NTERMS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .ina(ina4), .inb(inb4),
      .sel(sel4), .busy(busy4), .valid(valid4), .ready(ready4), .result(res4));
   secuenciador_mac #(.WIDTH(8), .NTERMS(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .ina(ina8), .inb(inb8),
      .sel(sel8), .busy(busy8), .valid(valid8), .ready(ready8), .result(res8));
   secuenciador_mac #(.WIDTH(8), .NTERMS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .ina(ina1), .inb(inb1),
      .sel(sel1), .busy(busy1), .valid(valid1), .ready(ready1), .result(res1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start4 = 0; ready4 = 0; start8 = 0; ready8 = 0; start1 = 0; ready1 = 0;
      for (int i = 0; i < 8; i++) begin
         a4[i] = 8'd0; b4[i] = 8'd0;
         a8[i] = 8'd255; b8[i] = 8'd255;
         a1[i] = 8'd0; b1[i] = 8'd0;
      end
      for (int i = 0; i < 4; i++) begin
         a4[i] = 8'(i+1); b4[i] = 8'(i+1);
      end
      a1[0] = 8'd7; b1[0] = 8'd9;

      // reset state
      tick(); tick();
      chk("rst_sel",    32'(sel4), 0);
      chk("rst_busy",   32'(busy4), 0);
      chk("rst_valid",  32'(valid4), 0);
      chk("rst_result", 32'(res4), 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy4), 0);

      // 4 terms {1,2,3,4}^2 -> 30, ready high throughout
      ready4 = 1; start4 = 1;
      tick();
      start4 = 0;
      chk("t2_sel0", 32'(sel4), 0);
      chk("t2_busy", 32'(busy4), 1);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("t2_sel", 32'(sel4), 32'(k));
         chk("t2_valid_lo", 32'(valid4), 0);
      end
      repeat (1 + EXTRA) tick();
      chk("t2_valid",  32'(valid4), 1);
      chk("t2_result", 32'(res4), 30);
      chk("t2_out_sel", 32'(sel4), 0);
      tick();
      chk("t2_accept_valid", 32'(valid4), 0);
      chk("t2_idle_busy",    32'(busy4), 0);

      // backpressure: {5,6,7,8}.{1,1,2,2} = 41, ready low, start pulses ignored
      a4[0] = 8'd5; a4[1] = 8'd6; a4[2] = 8'd7; a4[3] = 8'd8;
      b4[0] = 8'd1; b4[1] = 8'd1; b4[2] = 8'd2; b4[3] = 8'd2;
      ready4 = 0; start4 = 1;
      tick();
      start4 = 0;
      repeat (4 + EXTRA) tick();
      chk("t4_valid",  32'(valid4), 1);
      chk("t4_result", 32'(res4), 41);
      for (int i = 0; i < 5; i++) begin
         start4 = i[0];
         tick();
         chk("t4_hold_valid",  32'(valid4), 1);
         chk("t4_hold_result", 32'(res4), 41);
         chk("t4_hold_busy",   32'(busy4), 1);
      end
      start4 = 0; ready4 = 1;
      tick();
      chk("t4_release_valid", 32'(valid4), 0);
      chk("t4_release_busy",  32'(busy4), 0);

      // back-to-back: 30 then {2,2,2,2}.{1,2,3,4} = 20
      for (int i = 0; i < 4; i++) begin
         a4[i] = 8'(i+1); b4[i] = 8'(i+1);
      end
      start4 = 1; ready4 = 1;
      tick();
      repeat (4 + EXTRA) tick();
      chk("t5_first_valid",  32'(valid4), 1);
      chk("t5_first_result", 32'(res4), 30);
      for (int i = 0; i < 4; i++) a4[i] = 8'd2;
      tick();
      chk("t5_reissue_valid", 32'(valid4), 0);
      chk("t5_reissue_busy",  32'(busy4), 1);
      chk("t5_reissue_sel",   32'(sel4), 0);
      start4 = 0;
      tick();
      chk("t5_reissue_sel1",  32'(sel4), 1);
      repeat (3 + EXTRA) tick();
      chk("t5_second_valid",  32'(valid4), 1);
      chk("t5_second_result", 32'(res4), 20);
      tick();
      chk("t5_idle_busy", 32'(busy4), 0);

      // 8 terms of 255*255
      start8 = 1; ready8 = 1;
      tick();
      start8 = 0;
      chk("t3_sel0", 32'(sel8), 0);
      repeat (7) tick();
      chk("t3_sel7", 32'(sel8), 7);
      chk("t3_valid_lo", 32'(valid8), 0);
      repeat (1 + EXTRA) tick();
      chk("t3_valid",  32'(valid8), 1);
      chk("t3_result", 32'(res8), 520200);
      tick();
      chk("t3_idle_busy", 32'(busy8), 0);

      // single term 7*9, start held across the ISSUE cycle
      ready1 = 0; start1 = 1;
      tick();
      chk("t6_sel",   32'(sel1), 0);
      chk("t6_busy",  32'(busy1), 1);
      chk("t6_valid_lo", 32'(valid1), 0);
      tick();
      start1 = 0;
      repeat (EXTRA) tick();
      chk("t6_valid",  32'(valid1), 1);
      chk("t6_result", 32'(res1), 63);
      tick();
      chk("t6_hold_valid", 32'(valid1), 1);
      ready1 = 1;
      tick();
      chk("t6_idle_busy",  32'(busy1), 0);
      chk("t6_idle_valid", 32'(valid1), 0);

      // asynchronous reset in the middle of ISSUE
      start4 = 1; ready4 = 0;
      tick();
      start4 = 0;
      tick();
      chk("t1_pre_sel", 32'(sel4), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_sel",    32'(sel4), 0);
      chk("t1_async_busy",   32'(busy4), 0);
      chk("t1_async_valid",  32'(valid4), 0);
      chk("t1_async_result", 32'(res4), 0);
      chk("t1_async_res8",   32'(res8), 0);
      rst_n = 1'b1;
      tick();
      chk("t1_after_busy", 32'(busy4), 0);
      chk("t1_after_sel",  32'(sel4), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // absolute time guard
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
